ling_sub_seq: RTL and testbench
===============================

Name: ling_sub_seq

Overview:
- Multi-cycle unsigned subtractor: computes diff = a - b for WIDTH-bit operands, one 8-bit chunk per clock, least-significant chunk first.
- Each chunk is computed by a registered-borrow 8-bit Ling slice: a + ~b + carry, with carry chained through a flop between cycles.
- This is the subtract side of the datapath, complementing the 8-bit Ling adders.
- Uses a valid/ready handshake on both input and output. Sits between an operand source and a result consumer.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8 and >= 8 (elaboration error otherwise)
- NCHUNK, WIDTH/8, derived localparam; number of chunk cycles

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when a < b (unsigned)
- zero  output  1  1 when diff == 0
- ovf  output  1  signed overflow; present only with LING_SUB_OVF_EN

Behaviour:
- Reset: state=IDLE; out_valid=0, diff=0, borrow=0, zero=0, ovf=0. in_ready=1 in the cycle after reset deasserts.
- in_ready is 1 only in IDLE (combinational decode of state).
- FSM has three states: IDLE, RUN, DONE.
- IDLE -> RUN on in_valid & in_ready:
  - capture a, b into shift registers
  - carry flop = 1 (two's-complement +1)
  - chunk counter = 0
- RUN, each cycle:
  - slice computes {c, s} = a_q[7:0] + ~b_q[7:0] + carry
  - s shifts into the result register from the MSB end; carry <= c
  - a_q, b_q shift right 8; counter++
  - after the chunk with counter == NCHUNK-1, go to DONE
- DONE:
  - out_valid=1
  - diff is the full result; borrow = ~final carry; zero = (diff == 0)
  - diff, borrow, zero and ovf stay stable while out_valid & ~out_ready
  - on out_ready, go to IDLE and drop out_valid
- Latency: handshake in cycle T; out_valid asserts in cycle T+NCHUNK+1. With out_ready held high, throughput is one result per NCHUNK+2 cycles.
- in_valid during RUN/DONE is ignored (in_ready=0); operands are not buffered.
- out_ready while not out_valid has no effect.
- rst asserted mid-RUN or mid-DONE: the in-flight result is discarded, and the block returns to IDLE with reset output values next cycle.
- WIDTH=8: RUN lasts exactly 1 cycle.
- Carry-in of the first chunk is always 1. No external borrow-in.
- Ling slice:
  - bit-level p = a|~b, g = a&~b, d = a^~b
  - Ling pseudo-carry H[i] = G[i] | P[i-1]&G[i-2] from prefix group terms
  - the slice carry-in must be folded into bit 0 generate; the slice must honour cin
  - sum[i] = d[i] ^ carry-into-bit-i
  - carry-out = H[7] & p[7] | cin-propagated term

Optional Feature:
- Macro: LING_SUB_OVF_EN.
- Defined:
  - ovf port exists
  - ovf = (a_msb != b_msb) & (diff_msb != a_msb), computed during the last RUN chunk
  - registered with diff, reset 0, held in DONE
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ling_pkg holds:
  - state enum type: IDLE, RUN, DONE
  - constant CHUNK_W = 8
  - function to check WIDTH % CHUNK_W == 0
- One sub-module, ling8_cin: combinational 8-bit Ling adder with carry-in and carry-out (inputs a[7:0], b[7:0], cin; outputs s[7:0], cout).
  - The top instantiates it once with the b input inverted.
  - Verify ling8_cin standalone, exhaustively: 2^17 vectors.

Test Plan (WIDTH=32):
- a=0x00000005, b=0x00000003 -> diff=0x00000002, borrow=0, zero=0; out_valid exactly 5 cycles after accept.
- a=0x00000003, b=0x00000005 -> diff=0xFFFFFFFE, borrow=1, zero=0.
- a=b=0x12345678 -> diff=0, zero=1, borrow=0.
- Cross-chunk borrow: a=0x01000000, b=0x00000001 -> diff=0x00FFFFFF, borrow=0.
- Backpressure and reset:
  - hold out_ready=0 for 10 cycles: diff/borrow stay stable, in_ready=0, extra in_valid pulses are ignored
  - then out_ready=1 -> IDLE next cycle
  - rst during RUN -> out_valid stays 0; next transaction is correct
- LING_SUB_OVF_EN:
  - a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1
  - a=0x7FFFFFFF, b=0x00000001 -> ovf=0
  - plus 10k random pairs checked against a reference model

Source files
------------

// File: rtl/ling_pkg.sv
// ============================================================================
// Module : ling_pkg
// Brief  : Shared types and constants for the chunked Ling subtractor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ling_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal operand widths are whole, non-empty multiples of the slice width.
  function automatic bit width_ok(input int w);
    return (w >= CHUNK_W) && ((w % CHUNK_W) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ling8_cin.sv
// ============================================================================
// Module : ling8_cin
// Brief  : Combinational 8-bit Ling adder with carry-in and carry-out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ling8_cin (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [7:0] w_p;
  logic [7:0] w_g;
  logic [7:0] w_d;
  logic [7:0] w_h;
  logic [7:0] w_c;

  assign w_p = a | b;
  assign w_d = a ^ b;
  // Carry-in is absorbed into the bit-0 generate so the Ling chain needs no extra input.
  assign w_g = {a[7:1] & b[7:1], (a[0] & b[0]) | (w_p[0] & cin)};

  // H[i] = g[i] | p[i-1]&H[i-1]; the true carry out of bit i is p[i]&H[i].
  always_comb begin
    w_h    = '0;
    w_c    = '0;
    w_h[0] = w_g[0];
    w_c[0] = w_p[0] & w_h[0];
    for (int i = 1; i < 8; i++) begin
      w_h[i] = w_g[i] | (w_p[i-1] & w_h[i-1]);
      w_c[i] = w_p[i] & w_h[i];
    end
  end

  assign s    = w_d ^ {w_c[6:0], cin};
  assign cout = w_p[7] & w_h[7];

endmodule

`default_nettype wire

// File: rtl/ling_sub_seq.sv
// ============================================================================
// Module : ling_sub_seq
// Brief  : Multi-cycle unsigned subtractor, one 8-bit Ling chunk per clock.
//          Optional signed-overflow output enabled by macro LING_SUB_OVF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ling_sub_seq
  import ling_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
`ifdef LING_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (!width_ok(WIDTH)) begin : g_width_err
      $error("ling_sub_seq: WIDTH must be a multiple of 8 and >= 8");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic [WIDTH-1:0]   w_diff_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_borrow;
  logic               r_zero;
  logic [CHUNK_W-1:0] w_s;
  logic               w_cout;
  logic               w_last;

  assign w_last    = (r_cnt == CNT_W'(NCHUNK - 1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign zero      = r_zero;

  ling8_cin u_slice (
    .a    (r_a[CHUNK_W-1:0]),
    .b    (~r_b[CHUNK_W-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // New chunk enters at the MSB end so the LS chunk lands at bit 0 after NCHUNK shifts.
  generate
    if (NCHUNK == 1) begin : g_single
      assign w_diff_nxt = w_s;
    end else begin : g_multi
      assign w_diff_nxt = {w_s, r_diff[WIDTH-1:CHUNK_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK_W;
          r_b     <= r_b >> CHUNK_W;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          r_diff  <= w_diff_nxt;
          if (w_last) begin
            r_borrow <= ~w_cout;
            r_zero   <= (w_diff_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LING_SUB_OVF_EN
  logic r_ovf;

  // In the last chunk the low byte of the shift registers holds the operand sign bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= (r_a[CHUNK_W-1] != r_b[CHUNK_W-1]) && (w_s[CHUNK_W-1] != r_a[CHUNK_W-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ling_sub_seq.sv
// ============================================================================
// Module : tb_ling_sub_seq
// Brief  : Scoreboard bench for ling_sub_seq (WIDTH=32) plus exhaustive ling8_cin.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ling_sub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;
  logic        ovf_s;

  logic [7:0]  t_a, t_b, t_s;
  logic        t_cin, t_cout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] d;
    logic        br;
    logic        z;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ling_sub_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
`ifdef LING_SUB_OVF_EN
    ,
    .ovf       (ovf_s)
`endif
  );

`ifndef LING_SUB_OVF_EN
  assign ovf_s = 1'b0;
`endif

  ling8_cin u_slice_ref (
    .a    (t_a),
    .b    (t_b),
    .cin  (t_cin),
    .s    (t_s),
    .cout (t_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  // Monitor: a fresh result is popped and compared; a held result must not change.
  exp_t cur;
  bit   held = 1'b0;
  always @(negedge clk) begin
    if (out_valid) begin
      if (!held) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1'b1, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          chk("diff", diff, cur.d);
          chk("borrow", borrow, cur.br);
          chk("zero", zero, cur.z);
          chk("latency", cyc - cur.acc, 5);
`ifdef LING_SUB_OVF_EN
          chk("ovf", ovf_s, cur.ov);
`endif
        end
      end else begin
        chk("hold_diff", diff, cur.d);
        chk("hold_borrow", borrow, cur.br);
        chk("hold_zero", zero, cur.z);
      end
      held = !out_ready;
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ed,
                      input logic eb, input logic ez, input logic eo, input bit push);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 1'b0, 1'b1);
    end else begin
      a = av;
      b = bv;
      in_valid = 1'b1;
      if (push) begin
        e.d = ed; e.br = eb; e.z = ez; e.ov = eo; e.acc = cyc;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_model(input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] d;
    d = av - bv;
    send(av, bv, d, av < bv, d == 0, (av[31] != bv[31]) && (d[31] != av[31]), 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int errs;
    int nrand;
    logic [8:0] sum;

    // Exhaustive slice check while the sequential block sits in reset.
    errs = 0;
    for (int v = 0; v < (1 << 17); v++) begin
      t_a   = v[7:0];
      t_b   = v[15:8];
      t_cin = v[16];
      #1;
      sum = {1'b0, t_a} + {1'b0, t_b} + {8'd0, t_cin};
      if ({t_cout, t_s} !== sum) errs++;
    end
    chk("ling8_exhaustive_errs", errs, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 32'h0);
    chk("rst_borrow", borrow, 1'b0);
    chk("rst_zero", zero, 1'b0);
`ifdef LING_SUB_OVF_EN
    chk("rst_ovf", ovf_s, 1'b0);
`endif

    send(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h0100_0000, 32'h0000_0001, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: result held, in_ready low, stray in_valid pulses ignored.
    out_ready = 1'b0;
    send(32'h0000_1000, 32'h0000_0001, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      a = 32'hFFFF_FFFF;
      b = 32'h0;
      in_valid = (i % 3 == 0) && (i != 13);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_out_valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);

    // Reset in the middle of RUN discards the in-flight result.
    send(32'h0000_0005, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_diff", diff, 32'h0);
    chk("midrst_borrow", borrow, 1'b0);
    repeat (8) @(posedge clk);
    #1 chk("midrst_stays_idle", out_valid, 1'b0);
    send(32'hDEAD_BEEF, 32'h0000_BEEF, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

`ifdef LING_SUB_OVF_EN
    nrand = 10000;
`else
    nrand = 500;
`endif
    for (int i = 0; i < nrand; i++) begin
      send_model($urandom, $urandom);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
